dmem_responder: RTL and testbench

//  Memory-side responder for the core's data port: accepts one load/store request at a time and

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_lane_gen.sv | 39 +++
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
// The core's store-size decode uses the same size constants.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store path and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_gen.sv
// Store lane generation: byte enables, replicated lane data and alignment check.
// An illegal size is reported through misalign so the top sees a single error source.
module dmem_lane_gen
  import dmem_responder_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        misalign
);

  always_comb begin
    be        = 4'b0000;
    lane_data = 32'h0;
    misalign  = 1'b0;
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      SIZE_W: begin
        be        = 4'b1111;
        lane_data = wdata;
        misalign  = |addr_lo;
      end
      default: begin
        misalign  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, serviced from a word array after LATENCY edges.
// Loads return the whole aligned word; stores write only the enabled byte lanes.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  size_e       size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [3:0]  be;
  logic [31:0] lane_data;
  logic        misalign;
  logic [29:0] word_idx;
  logic        out_of_range;
  logic        access_err;
  logic        accept;
  logic        do_access;

  assign word_idx     = addr_q[31:2];
  assign out_of_range = (word_idx >= 30'(DEPTH));
  assign access_err   = misalign | out_of_range;
  assign accept       = bus.req_valid && (state_q == S_IDLE);
  assign do_access    = (state_q == S_WAIT) && (cnt_q == 4'd0);

  dmem_lane_gen u_lane_gen (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .be        (be),
    .lane_data (lane_data),
    .misalign  (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid)     state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0)     state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready)     state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Request latches, wait counter and response registers; the response holds until the next access.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= size_e'(bus.req_size);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt_q   <= 4'(LATENCY - 1);
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q   <= cnt_q - 4'd1;
      end
      if (do_access) begin
        rdata_q <= (!we_q && !access_err) ? mem[word_idx[AW-1:0]] : 32'h0;
        err_q   <= access_err;
      end
    end
  end

  // The array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && do_access && we_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx[AW-1:0]][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference model of the array.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: an access touches 2**size consecutive bytes starting at addr.
  function automatic void modelAccess(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int unsigned idx;
    int unsigned nbytes;
    int unsigned start;
    idx    = addr >> 2;
    nbytes = 1 << size;
    start  = addr % 4;
    err    = (size == 2'b11) || ((addr % nbytes) != 0) || (idx >= DEPTH);
    rdata  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < int'(nbytes); k++)
          model_mem[idx][8*(int'(start)+k) +: 8] = wdata[8*k +: 8];
      end else begin
        rdata = model_mem[idx];
      end
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    modelAccess(we, size, addr, wdata, exp_rdata, exp_err);
    if (stall == 0) bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_latency"}, n, LAT);
    for (int i = 0; i < stall; i++) begin
      checkOutput({tag, "_hold_valid"}, bus.rsp_valid, 1);
      checkOutput({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
      checkOutput({tag, "_hold_err"}, bus.rsp_err, exp_err);
      checkOutput({tag, "_no_accept"}, bus.req_ready, 0);
      @(posedge clk); #1;
    end
    checkOutput({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, bus.rsp_err, exp_err);
    last_rdata    = bus.rsp_rdata;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput({tag, "_rsp_drop"}, bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        seen;
    logic [31:0] addr;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_req_ready", bus.req_ready, 1);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("reset_rsp_err", bus.rsp_err, 0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= bus.rsp_valid;
    end
    checkOutput("idle_no_rsp", seen, 0);

    for (int w = 0; w < 16; w++)
      applyStimulus("fill", 1'b1, 2'b10, 32'(w * 4), $urandom, 0);

    applyStimulus("sw_10", 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 0);
    applyStimulus("lw_10", 1'b0, 2'b10, 32'h10, 32'h0, 0);
    checkOutput("lw_deadbeef", last_rdata, 32'hDEAD_BEEF);
    applyStimulus("sb_13", 1'b1, 2'b00, 32'h13, 32'h0000_00AA, 0);
    applyStimulus("sh_10", 1'b1, 2'b01, 32'h10, 32'h0000_1234, 0);
    applyStimulus("lw_merge", 1'b0, 2'b10, 32'h10, 32'h0, 0);
    checkOutput("lw_merge_const", last_rdata, 32'hAAAD_1234);

    applyStimulus("lh_11", 1'b0, 2'b01, 32'h11, 32'h0, 0);
    applyStimulus("lw_12", 1'b0, 2'b10, 32'h12, 32'h0, 0);
    applyStimulus("ill_size", 1'b0, 2'b11, 32'h10, 32'h0, 0);
    applyStimulus("lw_oor", 1'b0, 2'b10, 32'(4 * DEPTH), 32'h0, 0);
    applyStimulus("sw_12_err", 1'b1, 2'b10, 32'h12, 32'h5555_5555, 0);
    applyStimulus("sh_11_err", 1'b1, 2'b01, 32'h11, 32'h0000_6666, 0);
    applyStimulus("lw_after_err", 1'b0, 2'b10, 32'h10, 32'h0, 0);
    checkOutput("lw_after_err_const", last_rdata, 32'hAAAD_1234);

    applyStimulus("bp", 1'b0, 2'b10, 32'h10, 32'h0, 5);

    // Reset lands on the edge that would have committed the store.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_wait_ready", bus.req_ready, 1);
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      seen |= bus.rsp_valid;
    end
    checkOutput("rst_wait_no_rsp", seen, 0);
    applyStimulus("lw_20_after_rst", 1'b0, 2'b10, 32'h20, 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 15) == 0)
        addr = 32'((DEPTH + $urandom_range(0, 100)) * 4 + $urandom_range(0, 3));
      else
        addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      applyStimulus("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), addr, $urandom,
                    $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
